// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and index type for the register file and its hazard scoreboard.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits with a registered population count.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Clear is applied before set so a same-index issue wins over the write.
  always_comb begin
    busy_nxt = busy;
    if (we && (wr_addr != '0))
      busy_nxt[wr_addr] = 1'b0;
    if (iss_valid && (iss_addr != '0))
      busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with hazard scoreboard; r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding with REG_FILE_BYPASS_EN.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [ADDR_W-1:0] ra;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .we        (we),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (ra != '0) begin
        rd_data[i*DATA_W +: DATA_W] = mem[ra];
        rd_busy[i]                  = busy[ra];
`ifdef REG_FILE_BYPASS_EN
        // Forwarded write completes the pending op unless it is re-issued now.
        if (rst_n && we && (ra == wr_addr)) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data;
          rd_busy[i]                  = iss_valid && (iss_addr == wr_addr);
        end
`endif
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-008 SHALL have port rd_busy  output  NUM_RD  per-port flag: the addressed register has a pending write.
REQ-009 SHALL have port we  input  1  write enable.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write index.
REQ-011 SHALL have port wr_data  input  DATA_W  write data.
REQ-012 SHALL have port iss_valid  input  1  an instruction issues this cycle with a destination register.
REQ-013 SHALL have port iss_addr  input  ADDR_W  destination index of the issuing instruction.
REQ-014 SHALL have port busy_cnt  output  ADDR_W+1  registered count of pending destination registers.

Function
REQ-015 Register 0 SHALL read as zero on every port; writes to and issues against index 0 SHALL be ignored.
REQ-016 Reads SHALL be combinational: rd_data[i] = array[rd_addr[i]] in the same cycle, with no clock latency.
REQ-017 When we=1 and wr_addr!=0, array[wr_addr] SHALL take wr_data at the rising edge of clk.
REQ-018 Scoreboard: one busy bit per register; at the rising edge, iss_valid && iss_addr!=0 SHALL set busy[iss_addr], and we && wr_addr!=0 SHALL clear busy[wr_addr].
REQ-019 When set and clear target the same index in one cycle, set SHALL win and the bit SHALL remain 1.
REQ-020 Issue to an already-busy register SHALL leave the bit at 1; the next write to that index SHALL clear it (in-order pipeline, single bit per register, no counter).
REQ-021 rd_busy[i] SHALL be busy[rd_addr[i]], combinational; rd_busy for index 0 SHALL be 0.
REQ-022 busy_cnt SHALL equal the number of set busy bits after each edge; its value SHALL range 0..NREGS-1.
REQ-023 Writes and issues on different indices in the same cycle SHALL both take effect independently.

Reset
REQ-024 rst_n=0 SHALL immediately clear all array entries, all busy bits and busy_cnt to 0, regardless of clk.
REQ-025 While rst_n=0, rd_data SHALL read 0 on all ports, rd_busy SHALL be 0, and we/iss_valid SHALL be ignored.
REQ-026 An assertion of rst_n mid-operation SHALL discard all pending writes and scoreboard state; the first edge after deassertion SHALL behave as from cold.

Configuration
REQ-027 With REG_FILE_BYPASS_EN defined, a read port whose rd_addr equals wr_addr while we=1 and wr_addr!=0 SHALL return wr_data in the same cycle, and its rd_busy SHALL be 0 unless iss_valid && iss_addr==wr_addr.
REQ-028 Without REG_FILE_BYPASS_EN, reads SHALL return the stored array value only (write visible from the next cycle), and rd_busy SHALL reflect the busy bit only.

Structure
REQ-029 A shared package SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and the register index type, reused by the decode and hazard units.
REQ-030 The scoreboard (busy bits plus busy_cnt) SHALL be a sub-module named reg_scoreboard; the storage array and read muxing stay in reg_file_sb.

Verification
REQ-031 Reset: hold rst_n=0, drive we=1 wr_addr=3 wr_data=0xDEADBEEF -> after release, rd_addr=3 reads 0, busy_cnt=0.
REQ-032 Write/read: write 0x12345678 to r5 at edge N; rd_addr=5 reads 0x12345678 after edge N; write to r0 then read r0 -> 0.
REQ-033 Bypass: we=1 wr_addr=7 wr_data=0xA5A5A5A5, rd_addr=7 same cycle -> 0xA5A5A5A5 with REG_FILE_BYPASS_EN, old value without.
REQ-034 Scoreboard: issue r9 -> rd_busy=1 on r9, busy_cnt=1; write r9 -> rd_busy=0, busy_cnt=0; issue r0 -> busy_cnt stays 0.
REQ-035 Collision: same cycle iss_valid iss_addr=4 and we wr_addr=4, with r4 busy -> r4 busy remains 1, busy_cnt unchanged.
REQ-036 Mid-op reset: issue r1, r2, r3 (busy_cnt=3), pulse rst_n low between edges -> busy_cnt=0 and all rd_busy=0 immediately.
